v_operand_fetch: RTL and testbench



---
 rtl/v_operand_fetch.sv | 166 ++++++++++++++++
 tb/tb_v_operand_fetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_operand_fetch.sv
// Per-lane operand sequencer: walks RF rows, absorbs read latency, streams tuples.
// Optional third source port enabled by defining V_OPFETCH_VS3_EN.
module v_operand_fetch #(
   parameter int DATA_WIDTH = 32,
   parameter int RF_DEPTH   = 32,
   parameter int LEN_WIDTH  = 8,
   localparam int ADDR_W    = $clog2(RF_DEPTH),
`ifdef V_OPFETCH_VS3_EN
   localparam int NPORTS    = 3
`else
   localparam int NPORTS    = 2
`endif
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [ADDR_W-1:0]            req_vs1_i,
   input  logic [ADDR_W-1:0]            req_vs2_i,
`ifdef V_OPFETCH_VS3_EN
   input  logic [ADDR_W-1:0]            req_vs3_i,
`endif
   input  logic [LEN_WIDTH-1:0]         req_len_i,
   output logic [NPORTS*ADDR_W-1:0]     rf_read_addr_o,
   input  logic [NPORTS*DATA_WIDTH-1:0] rf_read_data_i,
   output logic                         op_valid_o,
   input  logic                         op_ready_i,
   output logic [NPORTS*DATA_WIDTH-1:0] op_data_o,
   output logic                         op_last_o,
   output logic                         busy_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_e;

   state_e                         state_q, state_d;
   logic [ADDR_W-1:0]              base_q [NPORTS];
   logic [ADDR_W-1:0]              req_base [NPORTS];
   logic [LEN_WIDTH-1:0]           len_q;
   logic [LEN_WIDTH-1:0]           idx_q;
   logic                           pend_q;
   logic                           pend_last_q;
   logic [NPORTS*DATA_WIDTH-1:0]   mem_q [2];
   logic                           last_q [2];
   logic                           wptr_q;
   logic                           rptr_q;
   logic [1:0]                     cnt_q, cnt_d;
   logic                           accept;
   logic                           issue;
   logic                           pop;
   logic                           push;
   logic                           last_row;
   logic [2:0]                     outstanding;

   always_comb begin
      req_base[0] = req_vs1_i;
      req_base[1] = req_vs2_i;
`ifdef V_OPFETCH_VS3_EN
      req_base[2] = req_vs3_i;
`endif
   end

   assign op_valid_o = (cnt_q != 2'd0);
   assign op_data_o  = mem_q[rptr_q];
   assign op_last_o  = op_valid_o & last_q[rptr_q];
   assign pop        = op_valid_o & op_ready_i;
   assign push       = pend_q;
   assign cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
   assign last_row   = (idx_q == len_q - LEN_WIDTH'(1));
   assign outstanding = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DRAIN exits as soon as the last tuple leaves this cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (req_len_i == '0) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            if (issue && last_row) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!pend_q && cnt_d == 2'd0) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o    = (state_q == S_IDLE);
      busy_o         = (state_q != S_IDLE);
      accept         = req_valid_i & (state_q == S_IDLE);
      issue          = (state_q == S_RUN) && (outstanding < 3'd2);
      rf_read_addr_o = '0;
      if (state_q == S_RUN) begin
         for (int k = 0; k < NPORTS; k++) begin
            rf_read_addr_o[k*ADDR_W +: ADDR_W] = base_q[k] + ADDR_W'(idx_q);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < NPORTS; k++) begin
            base_q[k] <= '0;
         end
         len_q       <= '0;
         idx_q       <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
      end else begin
         if (accept) begin
            for (int k = 0; k < NPORTS; k++) begin
               base_q[k] <= req_base[k];
            end
            len_q <= req_len_i;
            idx_q <= '0;
         end else if (issue) begin
            idx_q <= idx_q + LEN_WIDTH'(1);
         end
         pend_q      <= issue;
         pend_last_q <= issue & last_row;
      end
   end

   // Two-entry skid FIFO; entries hold the registered RF read data
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int e = 0; e < 2; e++) begin
            mem_q[e]  <= '0;
            last_q[e] <= 1'b0;
         end
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wptr_q]  <= rf_read_data_i;
            last_q[wptr_q] <= pend_last_q;
            wptr_q         <= ~wptr_q;
         end
         if (pop) begin
            rptr_q <= ~rptr_q;
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_v_operand_fetch.sv
// Scoreboard bench for v_operand_fetch with a registered-read RF model.
module tb_v_operand_fetch;

   localparam int DW = 32;
   localparam int AW = 5;
`ifdef V_OPFETCH_VS3_EN
   localparam int NP = 3;
`else
   localparam int NP = 2;
`endif

   logic             clk;
   logic             rst_i;
   logic             req_valid;
   logic             req_ready;
   logic [AW-1:0]    vs1, vs2;
`ifdef V_OPFETCH_VS3_EN
   logic [AW-1:0]    vs3;
`endif
   logic [7:0]       len;
   logic [NP*AW-1:0] rf_addr;
   logic [NP*DW-1:0] rf_data;
   logic             op_valid;
   logic             op_ready;
   logic [NP*DW-1:0] op_data;
   logic             op_last;
   logic             busy;

   int               runs;
   int               fails;
   int               n_pop;
   logic [NP*DW:0]   exp_q[$];

   v_operand_fetch dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_vs1_i      (vs1),
      .req_vs2_i      (vs2),
`ifdef V_OPFETCH_VS3_EN
      .req_vs3_i      (vs3),
`endif
      .req_len_i      (len),
      .rf_read_addr_o (rf_addr),
      .rf_read_data_i (rf_data),
      .op_valid_o     (op_valid),
      .op_ready_i     (op_ready),
      .op_data_o      (op_data),
      .op_last_o      (op_last),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file rows hold their own row number; one-cycle read latency
   always @(posedge clk) begin
      for (int k = 0; k < NP; k++) begin
         rf_data[k*DW +: DW] <= DW'(rf_addr[k*AW +: AW]);
      end
   end

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      runs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NP*DW-1:0] tup(int a, int b, int c);
      logic [NP*DW-1:0] t;
      t = '0;
      t[0 +: DW]  = DW'(a);
      t[DW +: DW] = DW'(b);
`ifdef V_OPFETCH_VS3_EN
      t[2*DW +: DW] = DW'(c);
`endif
      return t;
   endfunction

   task automatic expect_tup(int a, int b, int c, logic last);
      exp_q.push_back({last, tup(a, b, c)});
   endtask

   task automatic issue_req(int a, int b, int c, int n);
      req_valid = 1'b1;
      vs1 = AW'(a);
      vs2 = AW'(b);
`ifdef V_OPFETCH_VS3_EN
      vs3 = AW'(c);
`endif
      len = 8'(n);
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      cyc();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(int max);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", busy, 0);
      cyc();
      cyc();
      chk("sb_empty", exp_q.size(), 0);
   endtask

   task automatic monitor();
      logic [NP*DW:0] e;
      forever begin
         @(negedge clk);
         if (rst_i && op_valid && op_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
               chk("unexpected_tuple", op_data, 0);
               chk("unexpected_tuple_valid", op_valid, 0);
            end else begin
               e = exp_q.pop_front();
               chk("tuple_data", op_data, e[NP*DW-1:0]);
               chk("tuple_last", op_last, e[NP*DW]);
            end
         end
      end
   endtask

   task automatic stimulus();
      int p0;
      int wa[4];
      wa = '{30, 31, 0, 1};
      rst_i = 1'b0;
      req_valid = 1'b0;
      vs1 = '0;
      vs2 = '0;
`ifdef V_OPFETCH_VS3_EN
      vs3 = '0;
`endif
      len = '0;
      op_ready = 1'b1;
      #2;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_op_valid", op_valid, 0);
      chk("rst_op_last", op_last, 0);
      chk("rst_op_data", op_data, 0);
      chk("rst_rf_addr", rf_addr, 0);
      chk("rst_busy", busy, 0);
      cyc();
      cyc();
      rst_i = 1'b1;
      cyc();

      // streaming
      expect_tup(4, 10, 20, 0);
      expect_tup(5, 11, 21, 0);
      expect_tup(6, 12, 22, 0);
      expect_tup(7, 13, 23, 1);
      issue_req(4, 10, 20, 4);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk($sformatf("stream_valid_c%0d", c), op_valid, (c >= 3 && c <= 6));
         chk($sformatf("stream_busy_c%0d", c), busy, (c <= 6));
         cyc();
      end
      chk("stream_sb_empty", exp_q.size(), 0);

      // backpressure
      p0 = n_pop;
      op_ready = 1'b0;
      expect_tup(4, 10, 20, 0);
      expect_tup(5, 11, 21, 0);
      expect_tup(6, 12, 22, 0);
      expect_tup(7, 13, 23, 1);
      issue_req(4, 10, 20, 4);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c >= 3) begin
            chk($sformatf("bp_valid_c%0d", c), op_valid, 1);
            chk($sformatf("bp_hold_c%0d", c), op_data, tup(4, 10, 20));
            chk($sformatf("bp_last_c%0d", c), op_last, 0);
            chk($sformatf("bp_stall_addr_c%0d", c), rf_addr[0 +: AW], 6);
         end
         cyc();
      end
      op_ready = 1'b1;
      wait_idle(20);
      chk("bp_pop_count", n_pop - p0, 4);

      // address wrap
      expect_tup(30, 0, 5, 0);
      expect_tup(31, 1, 6, 0);
      expect_tup(0, 2, 7, 0);
      expect_tup(1, 3, 8, 1);
      issue_req(30, 0, 5, 4);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk($sformatf("wrap_addr0_c%0d", c), rf_addr[0 +: AW], wa[c-1]);
         chk($sformatf("wrap_addr1_c%0d", c), rf_addr[AW +: AW], c - 1);
         cyc();
      end
      wait_idle(20);

      // zero length
      p0 = n_pop;
      issue_req(3, 3, 3, 0);
      @(negedge clk);
      chk("zero_ready_c1", req_ready, 0);
      chk("zero_valid_c1", op_valid, 0);
      cyc();
      @(negedge clk);
      chk("zero_ready_c2", req_ready, 1);
      chk("zero_valid_c2", op_valid, 0);
      cyc();
      @(negedge clk);
      chk("zero_valid_c3", op_valid, 0);
      cyc();
      chk("zero_pop_count", n_pop - p0, 0);

      // reset during second tuple
      expect_tup(0, 16, 20, 0);
      issue_req(0, 16, 20, 8);
      cyc();
      cyc();
      cyc();
      rst_i = 1'b0;
      #1;
      chk("rmid_valid", op_valid, 0);
      chk("rmid_busy", busy, 0);
      chk("rmid_ready", req_ready, 1);
      chk("rmid_last", op_last, 0);
      chk("rmid_addr", rf_addr, 0);
      chk("rmid_sb", exp_q.size(), 0);
      cyc();
      rst_i = 1'b1;
      cyc();
      p0 = n_pop;
      expect_tup(5, 7, 9, 0);
      expect_tup(6, 8, 10, 1);
      issue_req(5, 7, 9, 2);
      wait_idle(20);
      chk("rmid_pop_count", n_pop - p0, 2);

`ifdef V_OPFETCH_VS3_EN
      expect_tup(1, 2, 3, 0);
      expect_tup(2, 3, 4, 1);
      issue_req(1, 2, 3, 2);
      wait_idle(20);
`endif

      $display("[TB] %0d tests run, %0d failed", runs, fails);
      $finish;
   endtask

   initial begin
      runs  = 0;
      fails = 0;
      n_pop = 0;
      fork
         monitor();
         stimulus();
      join_any
   end

endmodule
